pulse_gen_multi: RTL and testbench
==================================

// Module: pulse_gen_multi
// PURPOSE
//  N-channel programmable pulse generator; successor to the single fixed-ratio pulse divider.
//  Each channel has a run-time period and pulse width in CLK_IN cycles, periodic or one-shot mode,
//  a start tick and a one-shot completion flag. Drives UART baud/sample strobes, LED PWM, timeouts.
// PARAMETERS
//  CHANNELS   4   number of independent channels (>=1)
//  CNT_WIDTH  16  width of period/width fields and per-channel counter (>=2)
// PORTS
//  CLK_IN      in   1                   system clock, all logic on posedge
//  RST_IN      in   1                   synchronous reset, active-high
//  EN_IN       in   CHANNELS            per-channel enable (level)
//  ONESHOT_IN  in   CHANNELS            1 = one-shot mode, 0 = periodic
//  TRIG_IN     in   CHANNELS            one-shot start request (level, sampled in IDLE)
//  PERIOD_IN   in   CHANNELS*CNT_WIDTH  period in cycles; ch k at [k*CNT_WIDTH +: CNT_WIDTH]
//  WIDTH_IN    in   CHANNELS*CNT_WIDTH  high-time in cycles, same packing
//  PULSE_OUT   out  CHANNELS            registered pulse output
//  TICK_OUT    out  CHANNELS            registered 1-cycle strobe at each period start
//  DONE_OUT    out  CHANNELS            registered 1-cycle strobe when a one-shot period ends
//  BUSY_OUT    out  CHANNELS            1 while channel in RUN
// BEHAVIOUR
//  - Reset: every channel IDLE, counter 0, latches 0; PULSE/TICK/DONE/BUSY_OUT all 0.
//  - Per channel FSM: IDLE, RUN. Channels fully independent; all outputs registered.
//  - Start: IDLE->RUN on the edge where EN=1 and (ONESHOT=0 or TRIG=1).
//    At that edge: cnt<=0, latch P=max(PERIOD,1), Wd=WIDTH, mode=ONESHOT;
//    TICK<=1, PULSE<=(Wd>0), BUSY<=1. Latency EN/TRIG sample -> outputs: 1 cycle.
//  - RUN, each edge: cnt<=(cnt==P-1)?0:cnt+1; PULSE<=(next cnt < Wd); TICK<=(next cnt==0).
//  - P, Wd, mode re-latched only at period start (next cnt==0); mid-period input changes are
//    ignored until then. Wd=0: PULSE never high. Wd>=P: PULSE constant 1 in periodic mode.
//  - P=0 or P=1: TICK high every cycle; PULSE follows Wd>0.
//  - One-shot: on wrap edge (cnt==P-1) -> IDLE, DONE<=1 for one cycle, PULSE<=0, BUSY<=0.
//    TRIG during RUN ignored. TRIG held high: restart allowed on edge after DONE (IDLE 1 cycle).
//  - Periodic: runs while EN=1; mode latched 0 -> no DONE.
//  - EN=0 in RUN (either mode): next edge -> IDLE, cnt<=0, PULSE/TICK/BUSY<=0, no DONE.
//  - EN=0 takes priority over wrap; RST_IN priority over everything, mid-run returns to reset
//    state on the same edge.
//  - Counter compare uses CNT_WIDTH unsigned arithmetic; no overflow since cnt<=P-1<2^CNT_WIDTH.
// TESTING
//  1. ch0 periodic P=4 Wd=1, EN rises -> from next cycle PULSE 1,0,0,0 repeating; TICK same.
//  2. ch0 P=5 Wd=0 -> PULSE stays 0, TICK every 5; Wd=7 -> PULSE constant 1, TICK every 5.
//  3. ch1 P=4->8 mid-period (cnt=1) -> current period ends at 4, next period 8 cycles.
//  4. ch2 one-shot P=6 Wd=2, TRIG 1 cycle -> PULSE 1,1,0,0,0,0; DONE on 7th cycle; BUSY 6;
//     second TRIG at cnt=3 ignored.
//  5. RST_IN at cnt=2 of P=10, and separately EN drop at cnt=2 -> next cycle all outputs 0,
//     IDLE; no DONE.
//  6. CHANNELS=4: ch0..3 run P=2,3,4,5 simultaneously -> each TICK period exact, no cross-talk.

Source files
------------

// File: rtl/pulse_gen_multi_if.sv
// Bus bundle for pulse_gen_multi: per-channel controls toward the generator, strobes back.
// The master side drives the controls; the slave side (the generator) drives the strobes.
interface pulse_gen_multi_if #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 16
);
   logic [CHANNELS-1:0]           EN_IN;
   logic [CHANNELS-1:0]           ONESHOT_IN;
   logic [CHANNELS-1:0]           TRIG_IN;
   logic [CHANNELS*CNT_WIDTH-1:0] PERIOD_IN;
   logic [CHANNELS*CNT_WIDTH-1:0] WIDTH_IN;
   logic [CHANNELS-1:0]           PULSE_OUT;
   logic [CHANNELS-1:0]           TICK_OUT;
   logic [CHANNELS-1:0]           DONE_OUT;
   logic [CHANNELS-1:0]           BUSY_OUT;

   modport master (
      output EN_IN, ONESHOT_IN, TRIG_IN, PERIOD_IN, WIDTH_IN,
      input  PULSE_OUT, TICK_OUT, DONE_OUT, BUSY_OUT
   );

   modport slave (
      input  EN_IN, ONESHOT_IN, TRIG_IN, PERIOD_IN, WIDTH_IN,
      output PULSE_OUT, TICK_OUT, DONE_OUT, BUSY_OUT
   );
endinterface

// File: rtl/pulse_gen_multi.sv
// N-channel programmable pulse generator with periodic/one-shot modes.
// Each channel is an independent IDLE/RUN machine, and every output it drives is registered.
module pulse_gen_multi #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic               CLK_IN,
   input  logic               RST_IN,
   pulse_gen_multi_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      state_t               state, state_nxt;
      logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
      logic [CNT_WIDTH-1:0] per, per_nxt;
      logic [CNT_WIDTH-1:0] wid, wid_nxt;
      logic                 mode, mode_nxt;
      logic                 pulse_q, tick_q, done_q, busy_q;
      logic                 pulse_nxt, tick_nxt, done_nxt, busy_nxt;
      logic [CNT_WIDTH-1:0] per_in, wid_in, per_in_clamped, cnt_inc;
      logic                 en, start, wrap;

      assign en             = bus.EN_IN[k];
      assign per_in         = bus.PERIOD_IN[k*CNT_WIDTH +: CNT_WIDTH];
      assign wid_in         = bus.WIDTH_IN[k*CNT_WIDTH +: CNT_WIDTH];
      // A zero period behaves as one, so the channel ticks every cycle instead of stalling.
      assign per_in_clamped = (per_in == '0) ? CNT_WIDTH'(1) : per_in;
      assign start          = en && (!bus.ONESHOT_IN[k] || bus.TRIG_IN[k]);
      assign wrap           = (cnt == per - CNT_WIDTH'(1));
      assign cnt_inc        = cnt + CNT_WIDTH'(1);

      always_ff @(posedge CLK_IN) begin
         if (RST_IN) begin
            state   <= IDLE;
            cnt     <= '0;
            per     <= '0;
            wid     <= '0;
            mode    <= 1'b0;
            pulse_q <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            per     <= per_nxt;
            wid     <= wid_nxt;
            mode    <= mode_nxt;
            pulse_q <= pulse_nxt;
            tick_q  <= tick_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
         end
      end

      // Period, width and mode are only taken from the inputs when a new period begins.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         per_nxt   = per;
         wid_nxt   = wid;
         mode_nxt  = mode;
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  per_nxt   = per_in_clamped;
                  wid_nxt   = wid_in;
                  mode_nxt  = bus.ONESHOT_IN[k];
               end
            end
            RUN: begin
               if (!en) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (wrap) begin
                  cnt_nxt = '0;
                  if (mode) begin
                     state_nxt = IDLE;
                  end else begin
                     per_nxt  = per_in_clamped;
                     wid_nxt  = wid_in;
                     mode_nxt = bus.ONESHOT_IN[k];
                  end
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      always_comb begin
         pulse_nxt = 1'b0;
         tick_nxt  = 1'b0;
         done_nxt  = 1'b0;
         busy_nxt  = 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tick_nxt  = 1'b1;
                  pulse_nxt = (wid_in != '0);
                  busy_nxt  = 1'b1;
               end
            end
            RUN: begin
               if (en) begin
                  if (wrap && mode) begin
                     done_nxt = 1'b1;
                  end else if (wrap) begin
                     tick_nxt  = 1'b1;
                     pulse_nxt = (wid_in != '0);
                     busy_nxt  = 1'b1;
                  end else begin
                     pulse_nxt = (cnt_inc < wid);
                     busy_nxt  = 1'b1;
                  end
               end
            end
            default: begin
               busy_nxt = 1'b0;
            end
         endcase
      end

      assign bus.PULSE_OUT[k] = pulse_q;
      assign bus.TICK_OUT[k]  = tick_q;
      assign bus.DONE_OUT[k]  = done_q;
      assign bus.BUSY_OUT[k]  = busy_q;
   end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Scoreboard bench for pulse_gen_multi: stimulus queues hand-derived per-channel expectations,
// and a monitor compares them one cycle later, shortly after the clock edge.
module tb_pulse_gen_multi;
   localparam int CH = 4;
   localparam int CW = 16;

   logic CLK_IN = 1'b0;
   logic RST_IN;

   pulse_gen_multi_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

   pulse_gen_multi #(.CHANNELS(CH), .CNT_WIDTH(CW)) dut (
      .CLK_IN (CLK_IN),
      .RST_IN (RST_IN),
      .bus    (bus)
   );

   always #5 CLK_IN = ~CLK_IN;

   typedef struct packed {
      int         cyc;
      int         ch;
      logic [3:0] bits;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;

   task automatic apply_stimulus(input int ch, input bit en, input bit os, input bit trig,
                                 input int per, input int wid);
      bus.EN_IN[ch]               = en;
      bus.ONESHOT_IN[ch]          = os;
      bus.TRIG_IN[ch]             = trig;
      bus.PERIOD_IN[ch*CW +: CW]  = CW'(per);
      bus.WIDTH_IN[ch*CW +: CW]   = CW'(wid);
   endtask

   // Expected bits are {pulse, tick, done, busy} as seen after the next rising edge.
   task automatic expect_ch(input int ch, input string nm, input bit p, input bit t,
                            input bit d, input bit b);
      exp_t e;
      e.cyc  = cyc + 1;
      e.ch   = ch;
      e.bits = {p, t, d, b};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic step();
      @(negedge CLK_IN);
   endtask

   task automatic check_output(input exp_t e, input string nm);
      logic [3:0] got;
      got = {bus.PULSE_OUT[e.ch], bus.TICK_OUT[e.ch], bus.DONE_OUT[e.ch], bus.BUSY_OUT[e.ch]};
      checks++;
      if (e.cyc != cyc || got !== e.bits) begin
         errors++;
         $display("[TB] FAIL %s ch%0d cycle %0d (due %0d): pulse/tick/done/busy got %b want %b",
                  nm, e.ch, cyc, e.cyc, got, e.bits);
      end
   endtask

   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge CLK_IN);
         #1;
         cyc++;
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_output(e, nm);
         end
      end
   end

   initial begin
      RST_IN         = 1'b1;
      bus.EN_IN      = '0;
      bus.ONESHOT_IN = '0;
      bus.TRIG_IN    = '0;
      bus.PERIOD_IN  = '0;
      bus.WIDTH_IN   = '0;

      // Reset must dominate even with a channel enabled.
      apply_stimulus(0, 1, 0, 0, 4, 1);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < CH; k++) expect_ch(k, "reset", 0, 0, 0, 0);
         step();
      end
      RST_IN = 1'b0;

      for (int i = 0; i < 12; i++) begin
         expect_ch(0, "p4_w1", (i % 4) == 0, (i % 4) == 0, 0, 1);
         step();
      end
      apply_stimulus(0, 0, 0, 0, 4, 1);
      expect_ch(0, "p4_en_off", 0, 0, 0, 0);
      step();

      // Width 0 then 7 (>= period); the mid-period change lands only at the next wrap.
      apply_stimulus(0, 1, 0, 0, 5, 0);
      for (int i = 0; i < 20; i++) begin
         if (i == 7) apply_stimulus(0, 1, 0, 0, 5, 7);
         expect_ch(0, "p5_width", i >= 10, (i % 5) == 0, 0, 1);
         step();
      end
      apply_stimulus(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         expect_ch(0, "p0_w1", 1, 1, 0, 1);
         step();
      end
      apply_stimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         expect_ch(0, "p0_w0", 0, 1, 0, 1);
         step();
      end
      apply_stimulus(0, 0, 0, 0, 0, 0);
      expect_ch(0, "p0_off", 0, 0, 0, 0);
      step();

      // Period 4 -> 8 requested at cnt=1: ticks at 0, 4, 12.
      apply_stimulus(1, 1, 0, 0, 4, 2);
      for (int i = 0; i < 16; i++) begin
         if (i == 2) apply_stimulus(1, 1, 0, 0, 8, 2);
         expect_ch(1, "p4_to_p8",
                   (i == 0 || i == 1 || i == 4 || i == 5 || i == 12 || i == 13),
                   (i == 0 || i == 4 || i == 12), 0, 1);
         step();
      end
      apply_stimulus(1, 0, 0, 0, 8, 2);
      expect_ch(1, "p8_off", 0, 0, 0, 0);
      step();

      // One-shot with a stray trigger mid-run, then a held trigger restarting right after DONE.
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(2, 1, 1, (i == 0 || i == 3 || i == 4), 6, 2);
         if (i < 6)       expect_ch(2, "oneshot", i < 2, i == 0, 0, 1);
         else if (i == 6) expect_ch(2, "oneshot_done", 0, 0, 1, 0);
         else             expect_ch(2, "oneshot_idle", 0, 0, 0, 0);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(2, 1, 1, 1, 6, 2);
         if (i < 6)       expect_ch(2, "held_trig", i < 2, i == 0, 0, 1);
         else if (i == 6) expect_ch(2, "held_done", 0, 0, 1, 0);
         else             expect_ch(2, "held_restart", 1, 1, 0, 1);
         step();
      end
      apply_stimulus(2, 0, 1, 0, 6, 2);
      expect_ch(2, "oneshot_en_off", 0, 0, 0, 0);
      step();

      // Reset mid-run at cnt=2, then a one-shot killed by EN at cnt=2 must not raise DONE.
      apply_stimulus(3, 1, 0, 0, 10, 5);
      for (int i = 0; i < 3; i++) begin
         expect_ch(3, "p10_run", 1, i == 0, 0, 1);
         step();
      end
      RST_IN = 1'b1;
      for (int k = 0; k < CH; k++) expect_ch(k, "mid_reset", 0, 0, 0, 0);
      step();
      RST_IN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_ch(3, "p10_restart", 1, i == 0, 0, 1);
         step();
      end
      apply_stimulus(3, 0, 0, 0, 10, 5);
      expect_ch(3, "p10_en_off", 0, 0, 0, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(3, i < 3, 1, i == 0, 10, 5);
         if (i < 3) expect_ch(3, "os10_run", 1, i == 0, 0, 1);
         else       expect_ch(3, "os10_no_done", 0, 0, 0, 0);
         step();
      end

      // All channels together with periods 2..5.
      for (int k = 0; k < CH; k++) apply_stimulus(k, 1, 0, 0, k + 2, 1);
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < CH; k++)
            expect_ch(k, "multi", (i % (k + 2)) == 0, (i % (k + 2)) == 0, 0, 1);
         step();
      end
      for (int k = 0; k < CH; k++) apply_stimulus(k, 0, 0, 0, k + 2, 1);
      for (int k = 0; k < CH; k++) expect_ch(k, "multi_off", 0, 0, 0, 0);
      step();

      for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(posedge CLK_IN);
      #2;
      if (exp_q.size() > 0) begin
         errors += exp_q.size();
         $display("[TB] FAIL drain: %0d expectations never compared, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
